// File: rtl/tcam_result_serializer_pkg.sv
// Shared frame constants, FSM encoding and entry sizing for the TCAM result
// serializer and its queue.
package tcam_result_serializer_pkg;

  localparam logic START_BIT    = 1'b1;
  localparam logic STOP_BIT     = 1'b0;
  localparam logic TYPE_LOOKUP  = 1'b0;
  localparam logic TYPE_SETDONE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_TYPE  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  // A queued result is {type, id}.
  function automatic int entry_w(input int idwid);
    return idwid + 1;
  endfunction

endpackage

// File: rtl/tcam_result_serializer_fifo.sv
// Synchronous result queue with two ordered write ports (push1 lands behind
// push0 in the same cycle) and one read port; push and pop may coincide.
module result_fifo
  import tcam_result_serializer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push1) begin
      wr_ptr_d = wr_ptr_q + PTR_TWO;
    end else if (push0) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_q[wr_ptr_q] <= data0;
    end
    if (push1) begin
      mem_q[wr_ptr_q + PTR_ONE] <= data1;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/tcam_result_serializer.sv
// Turns TCAM lookup/set-done edges into queued, framed serial messages:
// START(1), TYPE, IDWID data bits MSB first, STOP(0); line idles low.
module tcam_result_serializer
  import tcam_result_serializer_pkg::*;
#(
  parameter int IDWID  = 8,
  parameter int DEPTH  = 4,
  parameter int BITDIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDWID-1:0] i_RuleID,
  input  logic             i_Valid,
  input  logic             i_SetDone,
  output logic             o_Serial,
  output logic             o_Busy,
  output logic             o_Overflow
);

  localparam int ENT_W = entry_w(IDWID);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int DIV_W = (BITDIV > 1) ? $clog2(BITDIV) : 1;
  localparam int BIT_W = (IDWID > 1) ? $clog2(IDWID) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BITDIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(IDWID - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic             valid_q, valid_d;
  logic             setdone_q, setdone_d;
  logic             overflow_q, overflow_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [ENT_W-1:0] cur_q, cur_d;

  logic             lk_ev, sd_ev;
  logic             acc_lk, acc_sd;
  logic [ENT_W-1:0] lk_entry, sd_entry;
  logic             push0, push1, pop;
  logic [ENT_W-1:0] data0;
  logic [ENT_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             bit_end;
  logic [IDWID-1:0] cur_id_d;

  // Stage 0: edge detection and admission into the queue
  always_comb begin
    valid_d   = i_Valid;
    setdone_d = i_SetDone;
    lk_ev     = i_Valid & ~valid_q;
    sd_ev     = i_SetDone & ~setdone_q;
    lk_entry  = {TYPE_LOOKUP, i_RuleID};
    sd_entry  = {TYPE_SETDONE, {IDWID{1'b0}}};

    // Lookup claims the first free slot; set-done only gets what is left.
    acc_lk = lk_ev & ~fifo_full;
    acc_sd = sd_ev & ((fifo_count + CNT_W'(acc_lk)) < CNT_W'(DEPTH));

    push0 = acc_lk | acc_sd;
    data0 = acc_lk ? lk_entry : sd_entry;
    push1 = acc_lk & acc_sd;

    overflow_d = overflow_q | (lk_ev & ~acc_lk) | (sd_ev & ~acc_sd);
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .data0 (data0),
    .push1 (push1),
    .data1 (sd_entry),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (div_q == DIV_LAST);

  // Stage 1: framing FSM
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cur_d   = cur_q;
    pop     = 1'b0;

    if (state_q == ST_IDLE) begin
      div_d = '0;
      if (!fifo_empty) begin
        pop     = 1'b1;
        cur_d   = fifo_head;
        state_d = ST_START;
      end
    end else begin
      div_d = bit_end ? '0 : (div_q + DIV_ONE);
      if (bit_end) begin
        case (state_q)
          ST_START: state_d = ST_TYPE;
          ST_TYPE: begin
            state_d = ST_DATA;
            bit_d   = BIT_MSB;
          end
          ST_DATA: begin
            if (bit_q == '0) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q - BIT_ONE;
            end
          end
          ST_STOP: begin
            // Back-to-back frames: next START follows STOP with no idle bit.
            if (!fifo_empty) begin
              pop     = 1'b1;
              cur_d   = fifo_head;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    cur_id_d = cur_d[IDWID-1:0];
    case (state_d)
      ST_IDLE:  serial_d = 1'b0;
      ST_START: serial_d = START_BIT;
      ST_TYPE:  serial_d = cur_d[IDWID];
      ST_DATA:  serial_d = cur_id_d[bit_d];
      ST_STOP:  serial_d = STOP_BIT;
      default:  serial_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE) | (~fifo_empty & ~pop);
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      serial_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      setdone_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      setdone_q  <= setdone_d;
    end
  end

  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  assign o_Serial   = serial_q;
  assign o_Busy     = busy_q;
  assign o_Overflow = overflow_q;

endmodule
